// File: rtl/cpx_io_req_sched_pkg.sv
// ============================================================================
// cpx_io_req_sched_pkg : shared sizes, FSM encodings and helpers for the
//                        CPX IO request scheduler.  Rev 1.0
// ============================================================================
`default_nettype none

package cpx_io_req_sched_pkg;

  localparam int NDEST  = 8;
  localparam int MAXOUT = 2;
  localparam int CW     = 2;
  localparam int PW     = $clog2(NDEST);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ATOM2 = 1'b1
  } state_e;

  function automatic logic [NDEST-1:0] dest_onehot(input logic [PW-1:0] idx);
    logic [NDEST-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  function automatic logic [PW-1:0] onehot_idx(input logic [NDEST-1:0] oh);
    logic [PW-1:0] idx;
    idx = '0;
    for (int i = 0; i < NDEST; i++) begin
      if (oh[i]) idx = idx | PW'(i);
    end
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cpx_rr_pick8.sv
// ============================================================================
// cpx_rr_pick8 : combinational round-robin one-hot picker; first set request
//                at or above the pointer, wrapping.  Rev 1.0
// ============================================================================
`default_nettype none

module cpx_rr_pick8
  import cpx_io_req_sched_pkg::*;
(
  input  logic [NDEST-1:0] req_i,
  input  logic [PW-1:0]    ptr_i,
  output logic [NDEST-1:0] pick_o,
  output logic             vld_o
);

  logic          found;
  logic [PW-1:0] idx;

  always_comb begin
    pick_o = '0;
    found  = 1'b0;
    idx    = '0;
    for (int i = 0; i < NDEST; i++) begin
      idx = ptr_i + PW'(i);
      if (!found && req_i[idx]) begin
        pick_o[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  assign vld_o = found;

endmodule

`default_nettype wire

// File: rtl/cpx_io_req_sched.sv
// ============================================================================
// cpx_io_req_sched : IO-side CPX request scheduler with per-destination credit
//                    tracking. Optional atomic pairs: CPX_IO_REQ_SCHED_ATOMIC_EN.
//                    Rev 1.0
// ============================================================================
`default_nettype none

module cpx_io_req_sched
  import cpx_io_req_sched_pkg::*;
(
  input  logic             rclk,
  input  logic             arst_l,
  input  logic             cfg_enable,
  input  logic [NDEST-1:0] iob_cpx_req_vld,
  input  logic [NDEST-1:0] cpx_io_grant_cx2,
`ifdef CPX_IO_REQ_SCHED_ATOMIC_EN
  input  logic [NDEST-1:0] iob_cpx_atom,
`endif
  output logic [NDEST-1:0] iob_cpx_deq,
  output logic [NDEST-1:0] io_cpx_req_cq,
  output logic             io_cpx_idle,
  output logic             io_cpx_cred_err
);

  logic [CW-1:0]    cnt_q [NDEST];
  logic [CW-1:0]    cnt_d [NDEST];
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    atom_dest_q, atom_dest_d;
  state_e           state_q, state_d;
  logic [NDEST-1:0] req_q;
  logic             idle_q, idle_d;
  logic             err_q, err_d;

  logic [NDEST-1:0] elig;
  logic [NDEST-1:0] rr_pick;
  logic             rr_vld;
  logic [PW-1:0]    pick_idx;
  logic [NDEST-1:0] deq;

  // Eligibility looks only at registered counts: a grant frees its slot next cycle.
  always_comb begin
    elig = '0;
    for (int d = 0; d < NDEST; d++) begin
      elig[d] = iob_cpx_req_vld[d] & (cnt_q[d] < CW'(MAXOUT)) & cfg_enable;
`ifdef CPX_IO_REQ_SCHED_ATOMIC_EN
      if (iob_cpx_atom[d] && (cnt_q[d] != '0)) elig[d] = 1'b0;
`endif
    end
  end

  cpx_rr_pick8 u_pick (
    .req_i  (elig),
    .ptr_i  (ptr_q),
    .pick_o (rr_pick),
    .vld_o  (rr_vld)
  );

  assign pick_idx = onehot_idx(rr_pick);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    atom_dest_d = atom_dest_q;
    deq         = '0;
    case (state_q)
      ST_IDLE: begin
        if (rr_vld) begin
          deq = rr_pick;
`ifdef CPX_IO_REQ_SCHED_ATOMIC_EN
          if (iob_cpx_atom[pick_idx]) begin
            state_d     = ST_ATOM2;
            atom_dest_d = pick_idx;
          end else begin
            ptr_d = pick_idx + PW'(1);
          end
`else
          ptr_d = pick_idx + PW'(1);
`endif
        end
      end
`ifdef CPX_IO_REQ_SCHED_ATOMIC_EN
      // Second half of an atomic pair is forced regardless of enable or valid.
      ST_ATOM2: begin
        deq     = dest_onehot(atom_dest_q);
        ptr_d   = atom_dest_q + PW'(1);
        state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    err_d  = err_q;
    idle_d = (state_d == ST_IDLE);
    for (int d = 0; d < NDEST; d++) begin
      cnt_d[d] = cnt_q[d];
      case ({deq[d], cpx_io_grant_cx2[d]})
        2'b10: cnt_d[d] = cnt_q[d] + CW'(1);
        2'b01: begin
          if (cnt_q[d] == '0) err_d = 1'b1;
          else                cnt_d[d] = cnt_q[d] - CW'(1);
        end
        default: cnt_d[d] = cnt_q[d];
      endcase
      if (cnt_d[d] != '0) idle_d = 1'b0;
    end
  end

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      for (int d = 0; d < NDEST; d++) cnt_q[d] <= '0;
      ptr_q       <= '0;
      atom_dest_q <= '0;
      state_q     <= ST_IDLE;
      req_q       <= '0;
      idle_q      <= 1'b1;
      err_q       <= 1'b0;
    end else begin
      for (int d = 0; d < NDEST; d++) cnt_q[d] <= cnt_d[d];
      ptr_q       <= ptr_d;
      atom_dest_q <= atom_dest_d;
      state_q     <= state_d;
      req_q       <= deq;
      idle_q      <= idle_d;
      err_q       <= err_d;
    end
  end

  assign iob_cpx_deq     = deq;
  assign io_cpx_req_cq   = req_q;
  assign io_cpx_idle     = idle_q;
  assign io_cpx_cred_err = err_q;

endmodule

`default_nettype wire

// File: tb/tb_cpx_io_req_sched.sv
// ============================================================================
// tb_cpx_io_req_sched : scoreboard bench with a behavioural credit/round-robin
//                       model. Honours CPX_IO_REQ_SCHED_ATOMIC_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_cpx_io_req_sched;

  logic       rclk = 1'b0;
  logic       arst_l = 1'b1;
  logic       cfg_enable = 1'b0;
  logic [7:0] vld = '0;
  logic [7:0] grant = '0;
  logic [7:0] atom = '0;
  logic [7:0] deq, req_cq;
  logic       idle, cred_err;

  always #5 rclk = ~rclk;

  cpx_io_req_sched dut (
    .rclk             (rclk),
    .arst_l           (arst_l),
    .cfg_enable       (cfg_enable),
    .iob_cpx_req_vld  (vld),
    .cpx_io_grant_cx2 (grant),
`ifdef CPX_IO_REQ_SCHED_ATOMIC_EN
    .iob_cpx_atom     (atom),
`endif
    .iob_cpx_deq      (deq),
    .io_cpx_req_cq    (req_cq),
    .io_cpx_idle      (idle),
    .io_cpx_cred_err  (cred_err)
  );

  typedef struct packed {
    logic [7:0] req;
    logic       idle;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: outstanding count per core, rotating priority start,
  // pending second half of an atomic pair (-1 when none), sticky error.
  int m_cnt[8];
  int m_ptr;
  int m_atom;
  bit m_err;
  int m_last;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic bit model_idle();
    bit r;
    r = (m_atom < 0);
    for (int d = 0; d < 8; d++) if (m_cnt[d] != 0) r = 0;
    return r;
  endfunction

  function automatic int model_pick(input logic [7:0] v, input logic en, input logic [7:0] a);
    int d;
    if (m_atom >= 0) return m_atom;
    if (!en) return -1;
    for (int i = 0; i < 8; i++) begin
      d = (m_ptr + i) % 8;
      if (v[d] && m_cnt[d] < 2 && (!a[d] || m_cnt[d] == 0)) return d;
    end
    return -1;
  endfunction

  task automatic model_step(input int p, input logic [7:0] g, input logic [7:0] a);
    int pk;
    for (int d = 0; d < 8; d++) begin
      pk = (p == d) ? 1 : 0;
      if (g[d] && m_cnt[d] == 0 && pk == 0) m_err = 1;
      else m_cnt[d] = m_cnt[d] + pk - int'(g[d]);
    end
    if (p >= 0) begin
      if (m_atom >= 0) begin
        m_atom = -1;
        m_ptr  = (p + 1) % 8;
      end else if (a[p]) begin
        m_atom = p;
      end else begin
        m_ptr = (p + 1) % 8;
      end
    end
    m_last = p;
  endtask

  task automatic model_reset();
    for (int d = 0; d < 8; d++) m_cnt[d] = 0;
    m_ptr  = 0;
    m_atom = -1;
    m_err  = 0;
    m_last = -1;
  endtask

  // One clock: drive at negedge, check the combinational pick, queue the
  // registered outputs expected after the following rising edge.
  task automatic cycle(input logic [7:0] v, input logic [7:0] g, input logic en,
                       input logic [7:0] a_in);
    logic [7:0] a, e;
    int p;
    exp_t x;
    a = a_in;
`ifndef CPX_IO_REQ_SCHED_ATOMIC_EN
    a = '0;
`endif
    @(negedge rclk);
    vld = v; grant = g; cfg_enable = en; atom = a;
    #1;
    p = model_pick(v, en, a);
    e = '0;
    if (p >= 0) e[p] = 1'b1;
    chk("deq", deq, e);
    model_step(p, g, a);
    x.req  = e;
    x.idle = model_idle();
    x.err  = m_err;
    exp_q.push_back(x);
    @(posedge rclk);
  endtask

  function automatic logic [7:0] legal_grants();
    logic [7:0] g;
    g = '0;
    for (int d = 0; d < 8; d++)
      if (m_cnt[d] > 0 && $urandom_range(0, 2) == 0) g[d] = 1'b1;
    return g;
  endfunction

  task automatic do_reset();
    #3;
    arst_l = 1'b0;
    vld = '0; grant = '0; atom = '0; cfg_enable = 1'b0;
    exp_q.delete();
    model_reset();
    #1;
    chk("rst_req", req_cq, 8'h00);
    chk("rst_idle", idle, 1'b1);
    chk("rst_err", cred_err, 1'b0);
    chk("rst_deq", deq, 8'h00);
    @(negedge rclk);
    arst_l = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge rclk);
      #1;
      if (arst_l && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("req_cq", req_cq, e.req);
        chk("idle", idle, e.idle);
        chk("cred_err", cred_err, e.err);
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [7:0] g;
    bit drained;
    model_reset();
    do_reset();

    // Single destination, then one credit returned, then same-cycle pick+grant.
    repeat (4) cycle(8'h01, 8'h00, 1'b1, 8'h00);
    chk("single_cnt0", m_cnt[0], 2);
    cycle(8'h01, 8'h01, 1'b1, 8'h00);
    repeat (2) cycle(8'h01, 8'h00, 1'b1, 8'h00);
    cycle(8'h01, 8'h01, 1'b1, 8'h00);
    cycle(8'h01, 8'h01, 1'b1, 8'h00);
    repeat (2) cycle(8'h01, 8'h00, 1'b1, 8'h00);

    // Round robin with every grant echoed one cycle later.
    do_reset();
    repeat (12) begin
      g = '0;
      if (m_last >= 0) g[m_last] = 1'b1;
      cycle(8'hFF, g, 1'b1, 8'h00);
    end

    // Randomised traffic.
    repeat (400) begin
      cycle(8'($urandom), legal_grants(), ($urandom_range(0, 7) != 0),
            ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00);
    end

    // Disabled with requests pending, then drain all credits.
    repeat (3) cycle(8'hFF, 8'h00, 1'b0, 8'h00);
    drained = 0;
    for (int i = 0; i < 40 && !drained; i++) begin
      g = '0;
      for (int d = 0; d < 8; d++) if (m_cnt[d] > 0) g[d] = 1'b1;
      cycle(8'hFF, g, 1'b0, 8'h00);
      drained = model_idle();
    end
    chk("drained", drained, 1'b1);
    cycle(8'h00, 8'h00, 1'b1, 8'h00);

    // Grant with no credit outstanding: sticky error.
    cycle(8'h00, 8'h10, 1'b1, 8'h00);
    repeat (3) cycle(8'h01, 8'h00, 1'b1, 8'h00);

`ifdef CPX_IO_REQ_SCHED_ATOMIC_EN
    do_reset();
    repeat (4) cycle(8'h06, 8'h00, 1'b1, 8'h04);
    chk("atom_cnt2", m_cnt[2], 2);
    cycle(8'h06, 8'h04, 1'b1, 8'h04);
    repeat (2) cycle(8'h06, 8'h00, 1'b1, 8'h04);
    cycle(8'h06, 8'h04, 1'b1, 8'h04);
    repeat (3) cycle(8'h06, 8'h00, 1'b1, 8'h04);
`endif

    // Reset in the middle of traffic.
    repeat (20) cycle(8'($urandom), legal_grants(), 1'b1, 8'h00);
    do_reset();
    repeat (10) cycle(8'($urandom), legal_grants(), 1'b1, 8'h00);

    @(posedge rclk);
    #2;
    chk("sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cpx_io_req_sched.md
Name: cpx_io_req_sched

Overview:
- IO-side scheduler for CPX requests to the 8 core destinations.
- Tracks outstanding requests per destination against the 2-entry CPX destination queue depth.
- Returns credits from the flopped grant vector cpx_io_grant_cx2.
- Picks at most one destination per cycle, round-robin, and drives the one-hot registered request plus a same-cycle dequeue strobe to the IO packet queues.

Parameters:
- NDEST, 8, number of CPX destinations (cores).
- MAXOUT, 2, maximum outstanding (ungranted) requests per destination.
- CW, 2, width of each outstanding counter; must satisfy 2^CW > MAXOUT.

Ports:
- rclk  input  1  clock.
- arst_l  input  1  asynchronous active-low reset.
- cfg_enable  input  1  when low, no new picks are made; an atomic pair already in progress still completes.
- iob_cpx_req_vld  input  NDEST  level; bit d high means the IO side has a packet queued for destination d.
- cpx_io_grant_cx2  input  NDEST  flopped CPX grant; each set bit returns one credit. Multiple bits may be set in one cycle.
- iob_cpx_deq  output  NDEST  combinational one-hot pick; IO pops the selected packet at this clock edge.
- io_cpx_req_cq  output  NDEST  registered one-hot request to CPX, asserted one cycle after the pick.
- io_cpx_idle  output  1  registered; high when all counters are 0 and the FSM is IDLE.
- io_cpx_cred_err  output  1  sticky; set when a grant arrives for a destination whose counter is 0.

Behaviour:
- Reset (async, arst_l=0) clears:
  - all counters;
  - round-robin pointer to 0;
  - FSM to IDLE;
  - io_cpx_req_cq=0, io_cpx_cred_err=0, io_cpx_idle=1.
  - Reset mid-operation discards any in-flight pair and all counts.
- Eligibility:
  - elig[d] = iob_cpx_req_vld[d] & (cnt[d] < MAXOUT) & cfg_enable.
  - Eligibility uses registered cnt only, so a grant in cycle t frees its credit from cycle t+1.
- Pick:
  - The first eligible d at or above the pointer, wrapping from NDEST-1 to 0.
  - iob_cpx_deq = onehot(pick) in the same cycle.
  - io_cpx_req_cq = that value registered, i.e. 1-cycle latency, 1-cycle pulse.
  - The pointer moves to pick+1 mod NDEST; it is unchanged when nothing is picked.
- Counters, per d: cnt_next = cnt + deq[d] - grant[d].
  - Simultaneous pick and grant leaves cnt unchanged.
  - A grant with cnt=0 and no same-cycle pick leaves cnt at 0 and sets io_cpx_cred_err.
  - A counter never exceeds MAXOUT.
- FSM:
  - IDLE is the only state without the optional feature.
  - With the optional feature, see below.
- io_cpx_idle: registered, from the next-state values.
- Grants for destinations never requested are ignored apart from the error flag.

Optional Feature:
- Macro: CPX_IO_REQ_SCHED_ATOMIC_EN. Adds input iob_cpx_atom (NDEST wide): bit d marks the head packet for d as the first half of an atomic pair.
- With the macro:
  - An atomic head for d is eligible only when cnt[d]==0.
  - Picking it moves the FSM IDLE→ATOM2 and latches d.
  - In ATOM2 the block forces deq/req to d for exactly one more cycle, regardless of the round-robin order, cfg_enable, or iob_cpx_req_vld.
  - The FSM then returns to IDLE. The pointer advances to d+1 only after the second half.
  - Net effect: the pair occupies consecutive req cycles, and cnt[d] reaches 2.
- Without the macro: the port is absent, there is no ATOM2 state, and every packet is single.

Decomposition:
- Shared include (iop-level defines): CPX destination count, queue depth (2), and FSM state encodings IDLE=1'b0 and ATOM2=1'b1.
- One sub-module: cpx_rr_pick8, a combinational round-robin one-hot picker (inputs: request vector and pointer; outputs: one-hot pick and valid). It is instantiated once.
- Counters, FSM and registers live in the top level.

Test Plan:
- Single destination:
  - Stimulus: iob_cpx_req_vld=8'h01 held, no grants.
  - Required response: deq=8'h01 in cycles 0 and 1; req_cq=8'h01 in cycles 1 and 2; then no picks; cnt[0]=2; io_cpx_idle=0.
- Credit return:
  - Stimulus: from the previous state, cpx_io_grant_cx2=8'h01 for one cycle.
  - Required response: cnt[0] becomes 1; the next cycle deq=8'h01; cnt[0] is back to 2.
- Round robin:
  - Stimulus: iob_cpx_req_vld=8'hFF with grants echoed back.
  - Required response: deq sequence 01,02,04,…,80,01; no destination is starved.
- Pick and grant on the same destination in the same cycle:
  - Required response: counter unchanged.
  - Stimulus: grant for a destination with cnt=0.
  - Required response: io_cpx_cred_err=1 and stays set until reset.
- Disable:
  - Stimulus: cfg_enable=0 with requests pending.
  - Required response: deq=0.
  - Stimulus: after all outstanding grants return.
  - Required response: io_cpx_idle=1.
  - Stimulus: assert arst_l=0 mid-traffic.
  - Required response: all outputs return immediately to their reset values.
- Atomic (CPX_IO_REQ_SCHED_ATOMIC_EN defined):
  - Stimulus: iob_cpx_atom=8'h04, iob_cpx_req_vld=8'h06, cnt[2]=0.
  - Required response: deq=04 for two consecutive cycles with dest 1 blocked meanwhile, then 02.
  - Stimulus: cnt[2]=1.
  - Required response: dest 2 is skipped until cnt[2]=0.
